regfile_mp: RTL and testbench

Parametrised successor to the core's 2-read/1-write integer register file. Adds configurable data width, register count and hard-zero register, plus same-cycle write-to-read bypass. Adds a hardware clear sequencer that zeroes every register after reset or on request. Sits between decode (read addresses) and writeback (write port) in the CPU pipeline.

---
 rtl/regfile_mp.sv | 238 +++++++++++++++++++++++
 tb/tb_regfile_mp.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// regfile_mp -- parametrised 2-read / 1-write integer register file
//
// Sits between decode (read addresses) and writeback (write port). Adds:
//   * configurable data width, register count and optional hard-zero x0
//   * write-first bypass: a write accepted in a cycle is visible to reads
//     issued in that same cycle
//   * a clear sequencer that zeroes every register after reset or on a
//     I_clear pulse. Accesses are refused while it runs (O_busy=1).
//
// Parameters
//   XLEN     data width of every register and data port
//   NREGS    number of architectural registers (>= 2, any value)
//   AW       address width, 2**AW >= NREGS
//   ZERO_REG 1: x0 reads as zero and ignores writes; 0: x0 is ordinary
//
// Ports
//   I_clk      clock, all state changes on the rising edge
//   I_reset    synchronous active-high reset, highest priority
//   I_clear    start (or restart) a full clear of all registers
//   I_data     write data
//   I_rd       write address
//   I_we       write enable
//   I_rs1      read port 1 address
//   I_rs2      read port 2 address
//   I_re       read enable for both ports
//   O_regval1  read port 1 data, registered, held when no read accepted
//   O_regval2  read port 2 data, registered, held when no read accepted
//   O_rvalid   one-cycle strobe: O_regval1/2 carry an accepted read
//   O_busy     clear sequencer running, reads and writes refused
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic            I_clk,
  input  logic            I_reset,
  input  logic            I_clear,
  input  logic [XLEN-1:0] I_data,
  input  logic [AW-1:0]   I_rd,
  input  logic            I_we,
  input  logic [AW-1:0]   I_rs1,
  input  logic [AW-1:0]   I_rs2,
  input  logic            I_re,
  output logic [XLEN-1:0] O_regval1,
  output logic [XLEN-1:0] O_regval2,
  output logic            O_rvalid,
  output logic            O_busy
);

  // One extra bit so that NREGS == 2**AW is still representable when
  // range-checking addresses.
  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [NREGS];

  logic [XLEN-1:0] regval1_q, regval2_q;
  logic            rvalid_q;

  logic            busy_s;
  logic            clr_we_s;
  logic            wr_ok_s;
  logic            rd_ok_s;
  logic            wr_in_range_s;
  logic            wr_is_zero_s;
  logic [XLEN-1:0] raw1_s, raw2_s;
  logic [XLEN-1:0] rd1_s, rd2_s;

  // Resolve the value a read port returns: out-of-range and hard-zero
  // addresses give 0, a same-cycle accepted write to the address wins,
  // otherwise the stored register content.
  function automatic logic [XLEN-1:0] resolve_read(
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] stored,
    input logic            wr_ok,
    input logic [AW-1:0]   wr_addr,
    input logic [XLEN-1:0] wr_data
  );
    logic [XLEN-1:0] v;
    if ({1'b0, addr} >= NREGS_W) begin
      v = {XLEN{1'b0}};
    end else if ((ZERO_REG == 1'b1) && (addr == {AW{1'b0}})) begin
      v = {XLEN{1'b0}};
    end else if (wr_ok && (wr_addr == addr)) begin
      v = wr_data;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  // Sequencer state and clear counter; reset forces a fresh clear.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer next state: I_clear (re)starts from index 0 in any state,
  // the edge that clears the last index returns to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (I_clear) begin
      state_d = ST_CLEAR;
      cnt_d   = {AW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          cnt_d   = {AW{1'b0}};
        end
        ST_CLEAR: begin
          if (cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
            cnt_d   = {AW{1'b0}};
          end else begin
            state_d = ST_CLEAR;
            cnt_d   = cnt_q + AW'(1);
          end
        end
        default: begin
          state_d = ST_CLEAR;
          cnt_d   = {AW{1'b0}};
        end
      endcase
    end
  end

  // Sequencer outputs, decoded from the state register only.
  always_comb begin
    busy_s   = 1'b0;
    clr_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_s   = 1'b0;
        clr_we_s = 1'b0;
      end
      ST_CLEAR: begin
        busy_s   = 1'b1;
        clr_we_s = 1'b1;
      end
      default: begin
        busy_s   = 1'b1;
        clr_we_s = 1'b0;
      end
    endcase
  end

  // Access qualification. A write needs an idle sequencer and loses to a
  // same-cycle clear or reset; a read only needs an idle sequencer.
  always_comb begin
    wr_in_range_s = ({1'b0, I_rd} < NREGS_W);
    if (ZERO_REG == 1'b1) begin
      wr_is_zero_s = (I_rd == {AW{1'b0}});
    end else begin
      wr_is_zero_s = 1'b0;
    end
    wr_ok_s = I_we & ~busy_s & ~I_clear & ~I_reset & wr_in_range_s & ~wr_is_zero_s;
    rd_ok_s = I_re & ~busy_s;
  end

  // Stored-value lookup for both read ports; addresses beyond NREGS find
  // no match and are forced to zero later by resolve_read.
  always_comb begin
    raw1_s = {XLEN{1'b0}};
    raw2_s = {XLEN{1'b0}};
    for (int i = 0; i < int'(NREGS); i++) begin
      if (I_rs1 == AW'(i)) begin
        raw1_s = regs_q[i];
      end else begin
        raw1_s = raw1_s;
      end
      if (I_rs2 == AW'(i)) begin
        raw2_s = regs_q[i];
      end else begin
        raw2_s = raw2_s;
      end
    end
  end

  // Final read data including bypass and zero rules.
  always_comb begin
    rd1_s = resolve_read(I_rs1, raw1_s, wr_ok_s, I_rd, I_data);
    rd2_s = resolve_read(I_rs2, raw2_s, wr_ok_s, I_rd, I_data);
  end

  // Register array. Not reset directly: the clear sequencer started by
  // reset zeroes every entry before any access is allowed. Sequencer and
  // port writes never coincide because port writes require an idle state.
  always_ff @(posedge I_clk) begin
    for (int i = 0; i < int'(NREGS); i++) begin
      if (clr_we_s && !I_reset && (cnt_q == AW'(i))) begin
        regs_q[i] <= {XLEN{1'b0}};
      end else if (wr_ok_s && (I_rd == AW'(i))) begin
        regs_q[i] <= I_data;
      end else begin
        regs_q[i] <= regs_q[i];
      end
    end
  end

  // Registered read port outputs; data holds when no read is accepted.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      regval1_q <= {XLEN{1'b0}};
      regval2_q <= {XLEN{1'b0}};
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= rd_ok_s;
      if (rd_ok_s) begin
        regval1_q <= rd1_s;
        regval2_q <= rd2_s;
      end
    end
  end

  assign O_regval1 = regval1_q;
  assign O_regval2 = regval2_q;
  assign O_rvalid  = rvalid_q;
  assign O_busy    = busy_s;

endmodule

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
// Testbench for regfile_mp. Two instances share one stimulus stream:
// A uses the default configuration (32 x 32, hard x0), B uses
// XLEN=64, NREGS=24, ZERO_REG=0 so addresses 24..31 are out of range.
// Every cycle the stimulus pushes the expected post-edge outputs of each
// instance into a queue; a monitor pops and compares after each edge.
module tb_regfile_mp;

  logic        clk;
  logic        rst, clr, we, re;
  logic [63:0] data;
  logic [4:0]  rd, rs1, rs2;

  logic [31:0] a_v1, a_v2;
  logic        a_rv, a_busy;
  logic [63:0] b_v1, b_v2;
  logic        b_rv, b_busy;

  regfile_mp dut_a (
    .I_clk(clk), .I_reset(rst), .I_clear(clr), .I_data(data[31:0]),
    .I_rd(rd), .I_we(we), .I_rs1(rs1), .I_rs2(rs2), .I_re(re),
    .O_regval1(a_v1), .O_regval2(a_v2), .O_rvalid(a_rv), .O_busy(a_busy)
  );

  regfile_mp #(.XLEN(64), .NREGS(24), .AW(5), .ZERO_REG(1'b0)) dut_b (
    .I_clk(clk), .I_reset(rst), .I_clear(clr), .I_data(data),
    .I_rd(rd), .I_we(we), .I_rs1(rs1), .I_rs2(rs2), .I_re(re),
    .O_regval1(b_v1), .O_regval2(b_v2), .O_rvalid(b_rv), .O_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rv;
    bit          busy;
    logic [63:0] v1;
    logic [63:0] v2;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int          checks = 0;
  int          errors = 0;
  bit          done   = 1'b0;

  // Reference model: architectural register contents, remaining busy
  // cycles and the currently presented output values, per instance.
  int          nr [2];
  bit          zr [2];
  logic [63:0] msk[2];
  logic [63:0] mdl[2][32];
  int          bl [2];
  logic [63:0] h1 [2];
  logic [63:0] h2 [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] mval(input int k, input int a, input bit wok,
                                       input int wa, input logic [63:0] d);
    if (a >= nr[k]) return 64'd0;
    if (zr[k] && a == 0) return 64'd0;
    if (wok && wa == a) return d & msk[k];
    return mdl[k][a];
  endfunction

  task automatic zero_all(input int k);
    for (int i = 0; i < 32; i++) mdl[k][i] = 64'd0;
  endtask

  task automatic model(input int k, input bit r, input bit c, input bit w, input int wa,
                       input logic [63:0] d, input bit e, input int a1, input int a2);
    exp_t x;
    bit   busy;
    bit   wok;
    busy = (bl[k] > 0);
    if (r) begin
      bl[k] = nr[k];
      zero_all(k);
      h1[k] = 64'd0;
      h2[k] = 64'd0;
      x.rv  = 1'b0;
    end else begin
      wok = w && !busy && !c && (wa < nr[k]) && !(zr[k] && wa == 0);
      if (e && !busy) begin
        h1[k] = mval(k, a1, wok, wa, d);
        h2[k] = mval(k, a2, wok, wa, d);
        x.rv  = 1'b1;
      end else begin
        x.rv  = 1'b0;
      end
      if (wok) mdl[k][wa] = d & msk[k];
      if (c) begin
        bl[k] = nr[k];
        zero_all(k);
      end else if (bl[k] > 0) begin
        bl[k]--;
      end
    end
    x.busy = (bl[k] > 0);
    x.v1   = h1[k];
    x.v2   = h2[k];
    if (k == 0) qa.push_back(x);
    else        qb.push_back(x);
  endtask

  task automatic step(input bit r, input bit c, input bit w, input int wa,
                      input logic [63:0] d, input bit e, input int a1, input int a2);
    @(negedge clk);
    rst  = r;
    clr  = c;
    we   = w;
    rd   = 5'(wa);
    data = d;
    re   = e;
    rs1  = 5'(a1);
    rs2  = 5'(a2);
    model(0, r, c, w, wa, d, e, a1, a2);
    model(1, r, c, w, wa, d, e, a1, a2);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b0, 0, 0);
  endtask

  // Noisy idle: random write/read attempts, which must be refused while busy.
  task automatic noisy(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b1, int'($urandom_range(31)), {$urandom, $urandom},
           1'b1, int'($urandom_range(31)), int'($urandom_range(31)));
  endtask

  // Monitor: compare every cycle's outputs with the oldest expectation.
  always begin
    exp_t ea;
    exp_t eb;
    @(posedge clk);
    #1;
    if (!done && qa.size() > 0) begin
      ea = qa.pop_front();
      chk("A_rvalid", {63'd0, a_rv},   {63'd0, ea.rv});
      chk("A_busy",   {63'd0, a_busy}, {63'd0, ea.busy});
      chk("A_regval1", {32'd0, a_v1}, ea.v1);
      chk("A_regval2", {32'd0, a_v2}, ea.v2);
    end
    if (!done && qb.size() > 0) begin
      eb = qb.pop_front();
      chk("B_rvalid", {63'd0, b_rv},   {63'd0, eb.rv});
      chk("B_busy",   {63'd0, b_busy}, {63'd0, eb.busy});
      chk("B_regval1", b_v1, eb.v1);
      chk("B_regval2", b_v2, eb.v2);
    end
  end

  initial begin
    nr[0] = 32; zr[0] = 1'b1; msk[0] = 64'h0000_0000_FFFF_FFFF;
    nr[1] = 24; zr[1] = 1'b0; msk[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      bl[k] = 0; h1[k] = 64'd0; h2[k] = 64'd0;
      zero_all(k);
    end
    rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
    data = 64'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;

    // Reset for one cycle, then busy window with refused accesses.
    step(1'b1, 1'b0, 1'b0, 0, 64'd0, 1'b0, 0, 0);
    noisy(32);
    step(1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b1, 5, 31);

    // Basic write/read and hard-zero x0 (ordinary on B).
    step(1'b0, 1'b0, 1'b1, 3, 64'h0000_0000_DEAD_BEEF, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b1, 3, 0);
    step(1'b0, 1'b0, 1'b1, 0, 64'h0000_0000_0000_1234, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b1, 0, 0);
    step(1'b0, 1'b0, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b1, 0, 3);
    // Out-of-range address on B (in range on A).
    step(1'b0, 1'b0, 1'b1, 30, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b1, 30, 30);

    // Same-cycle bypass on both ports, then stored value.
    step(1'b0, 1'b0, 1'b1, 7, 64'h5A5A_5A5A_A5A5_A5A5, 1'b1, 7, 7);
    nop(1);
    step(1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b1, 7, 7);

    // Fill, clear, access attempt mid-clear, then everything reads zero.
    for (int i = 1; i < 32; i++)
      step(1'b0, 1'b0, 1'b1, i, {$urandom, $urandom} | 64'h1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b1, 9, 17);
    step(1'b0, 1'b1, 1'b0, 0, 64'd0, 1'b0, 0, 0);
    nop(9);
    step(1'b0, 1'b0, 1'b1, 4, 64'h55, 1'b1, 4, 4);
    nop(22);
    for (int i = 0; i < 32; i += 2)
      step(1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b1, i, i + 1);

    // Clear restarted mid-sequence.
    step(1'b0, 1'b0, 1'b1, 12, 64'hCAFE, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 64'd0, 1'b0, 0, 0);
    nop(12);
    step(1'b0, 1'b1, 1'b0, 0, 64'd0, 1'b0, 0, 0);
    noisy(33);
    step(1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b1, 12, 1);

    // Reset in the middle of a clear.
    step(1'b0, 1'b0, 1'b1, 9, 64'hBEEF, 1'b1, 9, 9);
    step(1'b0, 1'b1, 1'b0, 0, 64'd0, 1'b0, 0, 0);
    nop(20);
    step(1'b1, 1'b0, 1'b1, 5, 64'h77, 1'b1, 5, 5);
    noisy(33);

    // Clear coinciding with an idle write and read: clear wins the write.
    step(1'b0, 1'b0, 1'b1, 6, 64'h66, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 6, 64'h99, 1'b1, 6, 6);
    nop(32);
    step(1'b0, 1'b0, 1'b0, 0, 64'd0, 1'b1, 6, 6);

    // Randomised traffic with occasional clears and resets.
    for (int n = 0; n < 600; n++) begin
      bit r, c, w, e;
      int wa, a1, a2;
      logic [63:0] d;
      r  = ($urandom_range(249) == 0);
      c  = ($urandom_range(79) == 0);
      w  = ($urandom_range(2) != 0);
      e  = ($urandom_range(3) != 0);
      wa = int'($urandom_range(31));
      a1 = ($urandom_range(3) == 0) ? wa : int'($urandom_range(31));
      a2 = ($urandom_range(3) == 0) ? wa : int'($urandom_range(31));
      case ($urandom_range(3))
        0:       d = 64'hFFFF_FFFF_FFFF_FFFF;
        default: d = {$urandom, $urandom};
      endcase
      step(r, c, w, wa, d, e, a1, a2);
    end
    nop(2);

    @(posedge clk);
    #3;
    chk("A_queue_drained", 64'(qa.size()), 64'd0);
    chk("B_queue_drained", 64'(qb.size()), 64'd0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
